// File: rtl/coin_pulse_gen.sv
// coin_pulse_gen: turns queued coin requests into width-coded coinSensor pulses.
// A small FIFO with a valid/ready handshake feeds a 3-state pulse FSM (IDLE, PULSE, GAP).
// Optional build macro COIN_JITTER_EN: pulse widths follow the offset cycle 0, -1, +1, 0.
module coin_pulse_gen #(
    parameter int NICKEL_LEN  = 7,
    parameter int DIME_LEN    = 3,
    parameter int QUARTER_LEN = 11,
    parameter int GAP_LEN     = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coinValid,
    input  logic [1:0]  coinType,
    output logic        coinReady,
    output logic        coinSensor,
    output logic        busy,
    output logic        badCoin,
    output logic [15:0] centsSent
);

    localparam int MAX_A = (NICKEL_LEN > DIME_LEN) ? NICKEL_LEN : DIME_LEN;
    localparam int MAX_B = (QUARTER_LEN > GAP_LEN) ? QUARTER_LEN : GAP_LEN;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;
    localparam int PW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [1:0]      cur_type;
    logic [1:0]      cur_type_next;
    logic            sensor_next;
    logic [15:0]     cents_next;

    logic [1:0]      fifo_mem [FIFO_DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic            full;
    logic            empty;
    logic            transfer;
    logic            push;
    logic            pop;
    logic [1:0]      head_type;
    logic [CW-1:0]   head_len;

    // Pointers carry a wrap bit so full and empty can be told apart when the indices match.
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign coinReady = !full;
    assign transfer  = coinValid && coinReady;
    assign push      = transfer && (coinType != 2'b00);
    assign pop       = (state == IDLE) && !empty;
    assign head_type = fifo_mem[rd_ptr[PW-1:0]];
    assign busy      = (state != IDLE) || !empty;

    function automatic logic [CW-1:0] base_len(input logic [1:0] t);
        case (t)
            2'b01:   base_len = CW'(NICKEL_LEN);
            2'b10:   base_len = CW'(DIME_LEN);
            default: base_len = CW'(QUARTER_LEN);
        endcase
    endfunction

    function automatic logic [15:0] coin_value(input logic [1:0] t);
        case (t)
            2'b01:   coin_value = 16'd5;
            2'b10:   coin_value = 16'd10;
            2'b11:   coin_value = 16'd25;
            default: coin_value = 16'd0;
        endcase
    endfunction

`ifdef COIN_JITTER_EN
    logic [1:0] jit_idx;

    // Rotate the jitter index once per emitted pulse so widths sweep the receiver windows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jit_idx <= 2'd0;
        end else if (pop) begin
            jit_idx <= jit_idx + 2'd1;
        end
    end

    // Apply the 0, -1, +1, 0 offset to the nominal width of the coin at the FIFO head.
    always_comb begin
        head_len = base_len(head_type);
        case (jit_idx)
            2'd1:    head_len = base_len(head_type) - CW'(1);
            2'd2:    head_len = base_len(head_type) + CW'(1);
            default: head_len = base_len(head_type);
        endcase
    end
`else
    assign head_len = base_len(head_type);
`endif

    // Queue storage; only legal codes are written, emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= coinType;
        end
    end

    // FIFO pointers and the one-cycle illegal-code strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            badCoin <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            badCoin <= transfer && (coinType == 2'b00);
        end
    end

    // FSM state, counters and the registered pulse output; reset truncates a pulse at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            cur_type   <= 2'b00;
            coinSensor <= 1'b0;
            centsSent  <= 16'd0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            cur_type   <= cur_type_next;
            coinSensor <= sensor_next;
            centsSent  <= cents_next;
        end
    end

    // Next-state logic: pop and raise, hold for the coin width, then hold low for the gap.
    always_comb begin
        state_next    = state;
        count_next    = count;
        cur_type_next = cur_type;
        sensor_next   = coinSensor;
        cents_next    = centsSent;
        case (state)
            IDLE: begin
                if (!empty) begin
                    cur_type_next = head_type;
                    count_next    = head_len;
                    sensor_next   = 1'b1;
                    state_next    = PULSE;
                end
            end
            PULSE: begin
                if (count == CW'(1)) begin
                    sensor_next = 1'b0;
                    cents_next  = centsSent + coin_value(cur_type);
                    count_next  = CW'(GAP_LEN);
                    state_next  = GAP;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            GAP: begin
                if (count == CW'(1)) begin
                    state_next = IDLE;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                sensor_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_coin_pulse_gen.sv
// tb_coin_pulse_gen: directed scoreboard bench for coin_pulse_gen.
// Expected pulse widths are queued at each handshake and compared as pulses complete.
module tb_coin_pulse_gen;

    localparam int GAP_LEN = 3;

    logic        clk;
    logic        reset;
    logic        coinValid;
    logic [1:0]  coinType;
    logic        coinReady;
    logic        coinSensor;
    logic        busy;
    logic        badCoin;
    logic [15:0] centsSent;

    int          total = 0;
    int          bad = 0;
    int          exp_q[$];
    logic [15:0] exp_cents = 16'd0;
    int          jit_idx = 0;
    logic        gap_check_en = 1'b0;

    logic        prev_s = 1'b0;
    int          high_cnt = 0;
    int          low_cnt = 0;
    logic        have_fall = 1'b0;

    coin_pulse_gen dut (
        .clk        (clk),
        .reset      (reset),
        .coinValid  (coinValid),
        .coinType   (coinType),
        .coinReady  (coinReady),
        .coinSensor (coinSensor),
        .busy       (busy),
        .badCoin    (badCoin),
        .centsSent  (centsSent)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_len(input logic [1:0] t);
        case (t)
            2'b01:   return 7;
            2'b10:   return 3;
            default: return 11;
        endcase
    endfunction

    function automatic logic [15:0] model_value(input logic [1:0] t);
        case (t)
            2'b01:   return 16'd5;
            2'b10:   return 16'd10;
            default: return 16'd25;
        endcase
    endfunction

    function automatic int jitter_off(input int idx);
`ifdef COIN_JITTER_EN
        case (idx)
            1:       return -1;
            2:       return 1;
            default: return 0;
        endcase
`else
        return 0 * idx;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        coinValid = 1'b0;
        coinType  = 2'b00;
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_cents = 16'd0;
        jit_idx   = 0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic send_coin(input logic [1:0] t, output int waited);
        waited    = 0;
        coinValid = 1'b1;
        coinType  = t;
        @(negedge clk);
        while (coinReady !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            check("ready_timeout", waited, 0);
            coinValid = 1'b0;
        end else begin
            @(posedge clk);
            if (t != 2'b00) begin
                exp_q.push_back(model_len(t) + jitter_off(jit_idx));
                jit_idx   = (jit_idx + 1) % 4;
                exp_cents = exp_cents + model_value(t);
            end
            #1 coinValid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        @(negedge clk);
        while (busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", (c >= budget), 0);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Pulse monitor: measures high and low runs and scores widths against the queue.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            prev_s    = 1'b0;
            high_cnt  = 0;
            low_cnt   = 0;
            have_fall = 1'b0;
        end else begin
            if (coinSensor === 1'b1) begin
                if (!prev_s && have_fall && gap_check_en) begin
                    check("gap_len", low_cnt, GAP_LEN + 1);
                end
                high_cnt++;
            end else begin
                if (prev_s) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", high_cnt, 0);
                    end else begin
                        check("pulse_width", high_cnt, exp_q.pop_front());
                    end
                    have_fall = 1'b1;
                    high_cnt  = 0;
                    low_cnt   = 0;
                end
                low_cnt++;
            end
            prev_s = coinSensor;
        end
    end

    // Directed sequence of scenarios.
    initial begin
        int waited;
        reset     = 1'b0;
        coinValid = 1'b0;
        coinType  = 2'b00;
        #1;
        check("rst_sensor", coinSensor, 0);
        check("rst_busy", busy, 0);
        check("rst_bad", badCoin, 0);
        check("rst_cents", centsSent, 0);
        check("rst_ready", coinReady, 1);
        apply_reset();

        $display("[TB] single dime");
        send_coin(2'b10, waited);
        @(negedge clk);
        check("dime_pre_rise", coinSensor, 0);
        check("dime_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dime_high", coinSensor, 1);
        end
        @(negedge clk);
        check("dime_fall", coinSensor, 0);
        repeat (3) @(negedge clk);
        check("dime_busy_clear", busy, 0);
        check("dime_cents", centsSent, 16'd10);
        check("dime_drained", exp_q.size(), 0);

        $display("[TB] illegal code");
        send_coin(2'b00, waited);
        check("bad_ready", waited, 0);
        @(negedge clk);
        check("bad_strobe", badCoin, 1);
        check("bad_no_busy", busy, 0);
        @(negedge clk);
        check("bad_strobe_end", badCoin, 0);
        repeat (4) @(negedge clk);
        check("bad_no_pulse", coinSensor, 0);
        check("bad_cents", centsSent, exp_cents);

        $display("[TB] Q N D Q back-to-back");
        apply_reset();
        gap_check_en = 1'b1;
        send_coin(2'b11, waited);
        check("qndq_ready0", waited, 0);
        send_coin(2'b01, waited);
        check("qndq_ready1", waited, 0);
        send_coin(2'b10, waited);
        check("qndq_ready2", waited, 0);
        send_coin(2'b11, waited);
        check("qndq_ready3", waited, 0);
        wait_idle(200);
        check("qndq_cents", centsSent, 16'd65);

        $display("[TB] fill FIFO while busy");
        apply_reset();
        send_coin(2'b01, waited);
        send_coin(2'b10, waited);
        send_coin(2'b11, waited);
        send_coin(2'b01, waited);
        send_coin(2'b10, waited);
        check("fifo_full_ready", coinReady, 0);
        send_coin(2'b11, waited);
        check("fifth_waited", (waited > 0), 1);
        wait_idle(300);
        check("fill_cents", centsSent, 16'd80);
        check("fill_cents_model", centsSent, exp_cents);
        gap_check_en = 1'b0;

        $display("[TB] reset mid-quarter");
        apply_reset();
        send_coin(2'b11, waited);
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("q_high_before_reset", coinSensor, 1);
        #2 reset = 1'b0;
        #1;
        check("async_sensor", coinSensor, 0);
        check("async_cents", centsSent, 0);
        check("async_busy", busy, 0);
        check("async_ready", coinReady, 1);
        apply_reset();
        send_coin(2'b01, waited);
        wait_idle(100);
        check("post_reset_cents", centsSent, 16'd5);

        $display("[TB] four dimes");
        apply_reset();
        gap_check_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_coin(2'b10, waited);
        end
        wait_idle(200);
        check("dimes_cents", centsSent, 16'd40);
        gap_check_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
